shift_unit_seq: RTL

Parametrised sequential shift/rotate unit. It is the multi-mode successor to the combinational 8-bit left shifter. It accepts a WIDTH-bit operand, a mode and a shift amount on a start/busy/done handshake, and shifts one bit position per clock. It returns the result, the last bit shifted out (carry_out) and a zero flag. It sits beside the ALU as the CPU's shift execution unit.

---
 rtl/shifter_pkg.sv | 14 +
 rtl/shift_step.sv | 40 ++++
 rtl/shift_unit_seq.sv | 97 +++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared mode and state encodings for the sequential shift/rotate unit.
package shifter_pkg;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One-bit-position shift/rotate step; bit_out is the bit that leaves the word.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] w,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] w_next,
  output logic             bit_out
);

  always_comb begin
    w_next  = w;
    bit_out = 1'b0;
    case (mode)
      MODE_LSL: begin
        bit_out = w[WIDTH-1];
        w_next  = {w[WIDTH-2:0], 1'b0};
      end
      MODE_LSR: begin
        bit_out = w[0];
        w_next  = {1'b0, w[WIDTH-1:1]};
      end
      MODE_ASR: begin
        bit_out = w[0];
        w_next  = {w[WIDTH-1], w[WIDTH-1:1]};
      end
      MODE_ROL: begin
        bit_out = w[WIDTH-1];
        w_next  = {w[WIDTH-2:0], w[WIDTH-1]};
      end
      default: begin
        w_next  = w;
        bit_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Sequential shift/rotate unit: one bit position per clock on a start/busy/done handshake.
module shift_unit_seq
  import shifter_pkg::*;
#(
  parameter  int WIDTH   = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] amount,
  input  logic [WIDTH-1:0]   in_bit,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out_bit,
  output logic               carry_out,
  output logic               zero
);

  state_t             state, state_next;
  logic [WIDTH-1:0]   work, step_w;
  logic [SHAMT_W-1:0] count;
  logic [1:0]         mode_q;
  logic               carry, step_bit;
  logic               load, step, finish;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .w       (work),
    .mode    (mode_q),
    .w_next  (step_w),
    .bit_out (step_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (count != '0) begin
          step = 1'b1;
        end else begin
          finish     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs move only on the finishing edge, so they hold through the next operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      work      <= '0;
      count     <= '0;
      mode_q    <= MODE_LSL;
      carry     <= 1'b0;
      out_bit   <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        work   <= in_bit;
        count  <= amount;
        mode_q <= mode;
        carry  <= 1'b0;
      end else if (step) begin
        work  <= step_w;
        carry <= step_bit;
        count <= count - 1'b1;
      end else if (finish) begin
        out_bit   <= work;
        carry_out <= carry;
        zero      <= (work == '0);
        done      <= 1'b1;
      end
    end
  end

  assign busy = (state == ST_SHIFT);

endmodule
